// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared types and control decode for the vector memory loader
package vec_pkg;

    localparam int unsigned LANES = 6;

    typedef logic [LANES-1:0][7:0] vec_word_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_START,
        S_RUN,
        S_DUMP,
        S_DONE
    } ld_state_e;

    typedef struct packed {
        logic in_ready;
        logic out_valid;
        logic cpu_start;
        logic mem_own;
        logic mem_we;
        logic busy;
        logic done;
    } ld_ctl_t;

    // Control outputs that hold for the whole time the loader sits in state s
    function automatic ld_ctl_t ctl_for(ld_state_e s);
        ld_ctl_t c;
        c           = '0;
        c.in_ready  = (s == S_LOAD);
        c.out_valid = (s == S_DUMP);
        c.cpu_start = (s == S_START);
        c.mem_own   = (s != S_START) && (s != S_RUN);
        c.mem_we    = (s == S_WRITE);
        c.busy      = (s != S_IDLE);
        c.done      = (s == S_DONE);
        return c;
    endfunction

endpackage

// File: rtl/byte_lane_cnt.sv
// rtl/byte_lane_cnt.sv - lane/word counter pair shared by load and dump phases
module byte_lane_cnt #(
    parameter int unsigned LANES = 6,
    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          lane_inc,
    input  logic          word_inc,
    input  logic [31:0]   words_m1,
    output logic [LW-1:0] lane_cnt,
    output logic [31:0]   word_cnt,
    output logic          lane_last,
    output logic          word_last
);

    assign lane_last = (lane_cnt == LW'(LANES - 1));
    assign word_last = (word_cnt == words_m1);

    // Word advance restarts the lane; lane advance wraps after the last lane
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            lane_cnt <= '0;
            word_cnt <= '0;
        end else if (word_inc) begin
            lane_cnt <= '0;
            word_cnt <= word_cnt + 32'd1;
        end else if (lane_inc) begin
            lane_cnt <= lane_last ? '0 : lane_cnt + LW'(1);
        end
    end

endmodule

// File: rtl/vec_mem_loader.sv
// rtl/vec_mem_loader.sv - packs a byte stream into vector memory, runs the CPU, streams results back
module vec_mem_loader #(
    parameter int unsigned LANES       = vec_pkg::LANES,
    parameter logic [31:0] LOAD_BASE   = 32'd0,
    parameter int unsigned LOAD_WORDS  = 64,
    parameter logic [31:0] DUMP_BASE   = 32'd64,
    parameter int unsigned DUMP_WORDS  = 64,
    parameter int unsigned RUN_TIMEOUT = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  cpu_start,
    input  logic                  cpu_end,
    output logic                  mem_own,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [LANES-1:0][7:0] mem_wdata,
    input  logic [LANES-1:0][7:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout
);
    import vec_pkg::*;

    localparam int unsigned LW       = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [31:0] RUN_LAST = 32'(RUN_TIMEOUT - 1);

    ld_state_e             state;
    ld_state_e             state_nxt;
    ld_ctl_t               ctl;
    logic [LANES-1:0][7:0] lanes;
    logic [31:0]           run_cnt;
    logic [LW-1:0]         lane_cnt;
    logic [31:0]           word_cnt;
    logic                  lane_last;
    logic                  word_last;
    logic                  load_hs;
    logic                  dump_hs;
    logic                  cnt_clr;
    logic                  lane_inc;
    logic                  word_inc;
    logic [31:0]           words_m1;

    assign {in_ready, out_valid, cpu_start, mem_own, mem_we, busy, done} = ctl;

    assign load_hs  = in_valid && in_ready;
    assign dump_hs  = out_valid && out_ready;
    assign words_m1 = (state == S_DUMP) ? 32'(DUMP_WORDS - 1) : 32'(LOAD_WORDS - 1);
    assign cnt_clr  = ((state == S_IDLE) && go) || ((state == S_RUN) && cpu_end);
    assign lane_inc = load_hs || (dump_hs && !lane_last);
    assign word_inc = (state == S_WRITE) || (dump_hs && lane_last);

    assign mem_wdata = (state == S_WRITE) ? lanes : '0;
    assign out_data  = (state == S_DUMP) ? mem_rdata[lane_cnt] : 8'h00;

    byte_lane_cnt #(
        .LANES (LANES)
    ) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .clr       (cnt_clr),
        .lane_inc  (lane_inc),
        .word_inc  (word_inc),
        .words_m1  (words_m1),
        .lane_cnt  (lane_cnt),
        .word_cnt  (word_cnt),
        .lane_last (lane_last),
        .word_last (word_last)
    );

    // Word address is only meaningful while writing or dumping; zero elsewhere
    always_comb begin
        mem_addr = 32'd0;
        if (state == S_WRITE) begin
            mem_addr = LOAD_BASE + word_cnt;
        end else if (state == S_DUMP) begin
            mem_addr = DUMP_BASE + word_cnt;
        end
    end

    // Next-state selection; cpu_end is checked before the run limit so it wins a tie
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (go) state_nxt = S_LOAD;
            S_LOAD:  if (load_hs && lane_last) state_nxt = S_WRITE;
            S_WRITE: state_nxt = word_last ? S_START : S_LOAD;
            S_START: state_nxt = S_RUN;
            S_RUN: begin
                if (cpu_end) begin
                    state_nxt = S_DUMP;
                end else if (run_cnt == RUN_LAST) begin
                    state_nxt = S_DONE;
                end
            end
            S_DUMP:  if (dump_hs && lane_last && word_last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register with control outputs registered from the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            ctl     <= ctl_for(S_IDLE);
            lanes   <= '0;
            run_cnt <= '0;
            timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            ctl   <= ctl_for(state_nxt);
            if ((state == S_IDLE) && go) begin
                timeout <= 1'b0;
            end
            if ((state == S_RUN) && (state_nxt == S_DONE)) begin
                timeout <= 1'b1;
            end
            if (load_hs) begin
                lanes[lane_cnt] <= in_data;
            end
            run_cnt <= (state == S_RUN) ? run_cnt + 32'd1 : 32'd0;
        end
    end

endmodule

// File: tb/tb_vec_mem_loader.sv
// tb/tb_vec_mem_loader.sv - directed self-checking bench for vec_mem_loader
module tb_vec_mem_loader;
    import vec_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        go;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        cpu_start;
    logic        cpu_end;
    logic        mem_own;
    logic        mem_we;
    logic [31:0] mem_addr;
    vec_word_t   mem_wdata;
    vec_word_t   mem_rdata;
    logic        busy;
    logic        done;
    logic        timeout;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          start_cnt = 0;
    int          ir_bad  = 0;
    int          stall_bad = 0;
    int          ov_cnt  = 0;
    int          we_cnt  = 0;
    bit          load_phase = 0;
    bit          prev_stall = 0;
    logic [7:0]  prev_data = 8'h00;
    logic [31:0] waddr_q[$];
    vec_word_t   wdata_q[$];
    logic [7:0]  out_q[$];
    vec_word_t   mem [0:127];

    always #5 clk = ~clk;

    vec_mem_loader #(
        .LANES       (LANES),
        .LOAD_BASE   (32'd0),
        .LOAD_WORDS  (2),
        .DUMP_BASE   (32'd64),
        .DUMP_WORDS  (1),
        .RUN_TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .go        (go),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cpu_start (cpu_start),
        .cpu_end   (cpu_end),
        .mem_own   (mem_own),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout)
    );

    assign mem_rdata = mem[mem_addr[6:0]];

    always @(posedge clk) cyc++;

    // Memory model and stream monitors, sampled mid-cycle
    always @(negedge clk) begin
        if (mem_we) begin
            we_cnt++;
            waddr_q.push_back(mem_addr);
            wdata_q.push_back(mem_wdata);
            if (mem_own) mem[mem_addr[6:0]] = mem_wdata;
        end
        if (cpu_start) start_cnt++;
        if (out_valid) ov_cnt++;
        if (out_valid && out_ready) out_q.push_back(out_data);
        if (load_phase && !cpu_start && !in_ready && !mem_we) ir_bad++;
        if (cpu_start) load_phase = 0;
        if (prev_stall && (!out_valid || out_data !== prev_data)) stall_bad++;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_flags"}, {in_ready, out_valid, cpu_start, mem_we, busy, done, timeout}, 7'd0);
        chk({tag, "_own"}, mem_own, 1'b1);
        chk({tag, "_addr"}, mem_addr, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 48'd0);
        chk({tag, "_odata"}, out_data, 8'd0);
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
        load_phase = 1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("send_timeout", 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic load_job(input bit bubbly);
        for (int i = 1; i <= 12; i++) begin
            if (bubbly) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) tick();
            end
            send_byte(8'(i));
        end
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (!cpu_start && n < 20) begin
            tick();
            n++;
        end
        chk("start_seen", cpu_start, 1'b1);
    endtask

    task automatic chk_writes(input string tag);
        chk({tag, "_nwr"}, waddr_q.size(), 2);
        if (waddr_q.size() == 2) begin
            chk({tag, "_a0"}, waddr_q[0], 32'd0);
            chk({tag, "_d0"}, wdata_q[0], 48'h060504030201);
            chk({tag, "_a1"}, waddr_q[1], 32'd1);
            chk({tag, "_d1"}, wdata_q[1], 48'h0C0B0A090807);
        end
    endtask

    task automatic chk_dump_bytes(input string tag);
        chk({tag, "_nbytes"}, out_q.size(), 6);
        for (int i = 0; i < out_q.size() && i < 6; i++) begin
            chk({tag, "_byte"}, out_q[i], 8'((i + 1) * 17));
        end
    endtask

    initial begin
        int         s;
        int         n;
        int         we0;
        bit         got_done;
        logic [7:0] pat;

        for (int i = 0; i < 128; i++) mem[i] = '0;
        mem[64]   = 48'h665544332211;
        reset     = 1'b1;
        go        = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cpu_end   = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("rst");
        reset = 1'b0;
        tick();
        chk_reset_outputs("idle");

        // Job 1: back-to-back load, cpu_end at RUN cycle 10, full-rate dump
        waddr_q.delete(); wdata_q.delete(); out_q.delete(); start_cnt = 0;
        pulse_go();
        chk("t1_load_ready", {busy, in_ready}, 2'b11);
        load_job(0);
        wait_start();
        chk("t1_start_own", mem_own, 1'b0);
        chk_writes("t1");
        tick();
        chk("t1_start_pulse", {cpu_start, mem_own, start_cnt[3:0]}, {1'b0, 1'b0, 4'd1});
        repeat (10) tick();
        cpu_end   = 1'b1;
        out_ready = 1'b1;
        tick();
        cpu_end = 1'b0;
        chk("t3_dump_addr", mem_addr, 32'd64);
        chk("t3_dump_own", mem_own, 1'b1);
        for (int i = 0; i < 6; i++) begin
            chk("t3_ovalid", out_valid, 1'b1);
            chk("t3_odata", out_data, 8'((i + 1) * 17));
            tick();
        end
        chk("t3_done", {done, out_valid, busy}, 3'b101);
        tick();
        chk("t3_after", {done, busy}, 2'b00);
        chk_dump_bytes("t3");

        // Job 2: bubbly load, stalling sink
        waddr_q.delete(); wdata_q.delete(); out_q.delete();
        ir_bad = 0; stall_bad = 0;
        pulse_go();
        load_job(1);
        wait_start();
        chk_writes("t2");
        chk("t2_inready_drops", ir_bad, 0);
        tick();
        tick();
        tick();
        cpu_end = 1'b1;
        tick();
        cpu_end  = 1'b0;
        pat      = 8'b0110_0101;
        n        = 0;
        got_done = 0;
        while (!got_done && n < 40) begin
            out_ready = pat[n % 8];
            tick();
            n++;
            if (done) got_done = 1;
        end
        out_ready = 1'b1;
        chk("t4_done", got_done, 1'b1);
        chk("t4_stall_stable", stall_bad, 0);
        chk_dump_bytes("t4");
        tick();

        // Job 3: CPU never ends; run limit of 16 cycles
        ov_cnt = 0;
        pulse_go();
        load_job(0);
        wait_start();
        s        = cyc;
        n        = 0;
        got_done = 0;
        while (!got_done && n < 40) begin
            tick();
            n++;
            if (done) got_done = 1;
        end
        chk("t5_done", got_done, 1'b1);
        chk("t5_latency", cyc - s, 17);
        chk("t5_timeout", {timeout, mem_own}, 2'b11);
        chk("t5_no_ovalid", ov_cnt, 0);
        tick();
        chk("t5_sticky", {timeout, busy}, 2'b10);
        pulse_go();
        chk("t5_go_clears", {timeout, busy}, 2'b01);

        // Job 4: reset after the third byte aborts the load
        send_byte(8'hA1);
        send_byte(8'hA2);
        send_byte(8'hA3);
        load_phase = 0;
        we0        = we_cnt;
        reset      = 1'b1;
        tick();
        chk_reset_outputs("t6_abort");
        reset    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (10) tick();
        in_valid = 1'b0;
        chk("t6_no_write", we_cnt - we0, 0);
        chk("t6_idle", {busy, in_ready, cpu_start}, 3'b000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vec_mem_loader.md
Name: vec_mem_loader

Overview:
- Host-side staging engine that sits upstream of the vector CPU and its data memory.
- Receives a byte stream, packs each 6 bytes into one 6x8-bit vector word and writes it into data memory.
- Then pulses the CPU start, waits for the CPU end flag, reads back a result region and streams it out byte by byte.
- Owns the data-memory port via a select output whenever the CPU is not running.

Parameters:
- LANES, 6, bytes per vector word; must match data memory word width.
- LOAD_BASE, 0, first word address written during load.
- LOAD_WORDS, 64, vector words loaded per job (>=1).
- DUMP_BASE, 64, first word address read during dump.
- DUMP_WORDS, 64, vector words dumped per job (>=1).
- RUN_TIMEOUT, 1000000, max cycles in RUN before abort.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- go  in  1  one-cycle pulse; starts a job when idle.
- in_data  in  8  inbound byte.
- in_valid  in  1  inbound byte valid.
- in_ready  out  1  loader accepts byte this cycle.
- out_data  out  8  outbound byte.
- out_valid  out  1  outbound byte valid.
- out_ready  in  1  sink accepts byte this cycle.
- cpu_start  out  1  one-cycle start pulse to CPU.
- cpu_end  in  1  CPU EndFlag.
- mem_own  out  1  1 = loader drives data-memory port; 0 = CPU drives it.
- mem_we  out  1  data-memory write enable.
- mem_addr  out  32  data-memory word address.
- mem_wdata  out  [LANES-1:0][7:0]  write vector.
- mem_rdata  in  [LANES-1:0][7:0]  read vector; asynchronous read, valid in the same cycle as mem_addr.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at job end.
- timeout  out  1  sticky error flag, cleared by go or reset.

Behaviour:
- Reset values:
  - State = IDLE.
  - mem_own = 1; every other output = 0, including mem_addr and mem_wdata.
  - Lane counter and word counter = 0.
- Reset mid-job aborts immediately: no further memory writes; cpu_start is not asserted.
- States: IDLE, LOAD, WRITE, START, RUN, DUMP, DONE.
- IDLE:
  - in_ready = 0.
  - go moves to LOAD, clears timeout and zeroes the counters.
  - go while busy is ignored.
- LOAD:
  - in_ready = 1.
  - Each in_valid&in_ready handshake stores in_data into lane[lane_cnt]; the first byte goes to lane 0.
  - When lane LANES-1 is stored, go to WRITE.
- WRITE, one cycle:
  - mem_we = 1, mem_addr = LOAD_BASE + word_cnt, mem_wdata = packed lanes; in_ready = 0.
  - Next cycle: word_cnt++ and lane_cnt = 0.
  - If word_cnt was LOAD_WORDS-1, go to START; otherwise return to LOAD.
- START, one cycle:
  - cpu_start = 1 and mem_own = 0, both in this cycle.
  - Go to RUN with the cycle counter at 0.
- RUN:
  - mem_own = 0, mem_we = 0.
  - cpu_end high goes to DUMP and resets word_cnt/lane_cnt.
  - If the counter reaches RUN_TIMEOUT-1 without cpu_end: set timeout, go to DONE, skip the dump.
  - If cpu_end and the timeout limit coincide, cpu_end wins.
- DUMP:
  - mem_own = 1, mem_addr = DUMP_BASE + word_cnt.
  - out_data = mem_rdata[lane_cnt], out_valid = 1.
  - out_data holds stable while out_valid && !out_ready.
  - Each handshake advances lane_cnt. After lane LANES-1 it wraps to 0 and word_cnt++.
  - After the last byte of word DUMP_WORDS-1, go to DONE.
- DONE, one cycle: done = 1, mem_own = 1, then back to IDLE.
- busy = 1 in every state except IDLE.
- Address arithmetic: 32-bit, wraps modulo 2^32 with no error.
- Throughput:
  - Load takes LANES handshakes plus 1 write cycle per word.
  - Dump sustains 1 byte per cycle when out_ready is held high.

Decomposition:
- Shared package vec_pkg:
  - LANES constant.
  - vec_word_t typedef (logic [LANES-1:0][7:0]).
  - Loader state enum.
- One natural sub-module, byte_lane_cnt: a lane/word counter pair with wrap and last-flag outputs, instantiated once for load and reused for dump.

Test Plan:
1. LOAD_WORDS=2, DUMP_WORDS=1, bytes 0x01..0x0C -> write of {0x06..0x01} to address 0, then {0x0C..0x07} to address 1, then a one-cycle cpu_start pulse.
2. Bubbly in_valid (random gaps) with the same 12 bytes -> identical memory writes; in_ready drops only in WRITE.
3. cpu_end at RUN cycle 10 with memory word 64 = {0x66,0x55,0x44,0x33,0x22,0x11}, out_ready held high -> out_data 0x11,0x22,...,0x66 on 6 consecutive cycles, then done pulse.
4. out_ready toggling 1-0-1 during dump -> out_data is stable while stalled and no byte is lost or duplicated.
5. RUN_TIMEOUT=16 and cpu_end never asserted -> timeout=1 and done pulse 16 cycles after START; no out_valid; mem_own returns to 1.
6. reset asserted after the 3rd load byte -> next cycle state is IDLE, all outputs are at reset values, and no mem_we occurs afterwards.
